// File: rtl/alu_regfile_sequencer_pkg.sv
// Shared constants, state encoding and decode helpers
// for the register-file/ALU instruction sequencer.
package alu_regfile_sequencer_pkg;

  localparam logic [3:0] FN_NOP = 4'b0000;
  localparam logic [3:0] FN_AND = 4'b0001;
  localparam logic [3:0] FN_OR  = 4'b0010;
  localparam logic [3:0] FN_XOR = 4'b0011;
  localparam logic [3:0] FN_ADD = 4'b0101;
  localparam logic [3:0] FN_SUB = 4'b1001;
  localparam logic [3:0] FN_CMP = 4'b1011;
  localparam logic [3:0] FN_MOV = 4'b1101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_EXEC   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT_STEP = ST_WAIT,
    S_DECODE    = ST_DECODE,
    S_EXEC      = ST_EXEC
  } state_t;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int FN_LSB = 4;
  localparam int RS_LSB = 0;
  localparam int IMM_W  = 8;

  localparam int FLG_N = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_F = 2;
  localparam int FLG_L = 3;
  localparam int FLG_C = 4;

  typedef struct packed {
    logic [3:0]  func;
    logic [15:0] imm;
    logic        imm_sel;
  } dec_t;

  function automatic logic fn_legal(
    input logic [3:0] f
  );
    case (f)
      FN_AND, FN_OR, FN_XOR,
      FN_ADD, FN_SUB, FN_CMP,
      FN_MOV:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic fn_zext(
    input logic [3:0] f
  );
    return (f == FN_AND) ||
           (f == FN_OR)  ||
           (f == FN_XOR);
  endfunction

  function automatic dec_t decode(
    input logic [15:0] ir
  );
    dec_t       d;
    logic [3:0] op;
    op        = ir[OP_LSB +: 4];
    d.imm_sel = (op != 4'h0);
    d.func    = d.imm_sel ? op
                          : ir[FN_LSB +: 4];
    unique case (1'b1)
      fn_zext(d.func):
        d.imm = {8'h00, ir[IMM_W-1:0]};
      default:
        d.imm = {{8{ir[IMM_W-1]}},
                 ir[IMM_W-1:0]};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile_sequencer_if.sv
// Instruction valid/ready channel between the
// instruction source (master) and the sequencer (slave).
interface alu_regfile_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/alu_regfile_sequencer_step_edge_detect.sv
// Two-flop synchronizer plus rising-edge detector
// for the single-step button input.
module step_edge_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic i_d,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_d};
      r_prev <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/alu_regfile_sequencer.sv
// Three-phase IDLE/DECODE/EXEC sequencer for the regfile/ALU pair.
// Optional SINGLE_STEP_EN adds a WAIT_STEP state gated by a step edge.
module alu_regfile_sequencer
  import alu_regfile_sequencer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int FLAG_W = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  alu_regfile_sequencer_if.slave ibus,
  input  logic              step,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  output logic [3:0]        alu_func,
  output logic [15:0]       imm,
  output logic              imm_sel,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [FLAG_W-1:0] psr,
  output logic              busy,
  output logic [CNT_W-1:0]  instr_count
);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_ir;
  logic [3:0]        r_func;
  logic [15:0]       r_imm;
  logic              r_imm_sel;
  logic [FLAG_W-1:0] r_psr;
  logic [CNT_W-1:0]  r_count;
  dec_t              w_dec;
  logic              w_accept;

`ifdef SINGLE_STEP_EN
  logic w_step_rise;

  step_edge_detect u_step (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_d    (step),
    .o_rise (w_step_rise)
  );
`else
  logic w_unused_step;
  assign w_unused_step = step;
`endif

  assign w_dec    = decode(r_ir);
  assign w_accept = (r_state == S_IDLE) &&
                    ibus.instr_valid;

  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (ibus.instr_valid) begin
`ifdef SINGLE_STEP_EN
          w_next = S_WAIT_STEP;
`else
          w_next = S_DECODE;
`endif
        end
      end
      S_WAIT_STEP: begin
`ifdef SINGLE_STEP_EN
        if (w_step_rise) w_next = S_DECODE;
`else
        w_next = S_IDLE;
`endif
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = S_IDLE;
    endcase
  end

  // Decoded ALU controls are registered so they
  // hold their last values once back in IDLE.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_ir      <= 16'h0000;
      r_func    <= FN_NOP;
      r_imm     <= 16'h0000;
      r_imm_sel <= 1'b0;
      r_psr     <= '0;
      r_count   <= '0;
    end else begin
      if (w_accept) r_ir <= ibus.instr;
      if (r_state == S_DECODE) begin
        r_func    <= w_dec.func;
        r_imm     <= w_dec.imm;
        r_imm_sel <= w_dec.imm_sel;
      end
      if (r_state == S_EXEC) begin
        r_count <= r_count + CNT_W'(1);
        if (fn_legal(r_func)) r_psr <= flags_in;
      end
    end
  end

  assign ibus.instr_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign rf_raddr_a  = r_ir[RD_LSB +: 4];
  assign rf_raddr_b  = r_ir[RS_LSB +: 4];
  assign rf_waddr    = r_ir[RD_LSB +: 4];
  assign alu_func    = r_func;
  assign imm         = r_imm;
  assign imm_sel     = r_imm_sel;
  assign psr         = r_psr;
  assign instr_count = r_count;
  assign rf_we       = (r_state == S_EXEC) &&
                       fn_legal(r_func) &&
                       (r_func != FN_CMP);

endmodule
